// File: rtl/uart_sched_if.sv
// Bundle between the scheduler, its two requesters and the shared uart.
// The master modport is the scheduler side; the slave modport is the surrounding logic.
interface uart_sched_if #(
  parameter int unsigned DBIT = 8
);
  logic [1:0]      req;
  logic [DBIT-1:0] cmd_data0;
  logic [DBIT-1:0] cmd_data1;
  logic [1:0]      cmd_valid;
  logic [1:0]      cmd_last;
  logic [1:0]      cmd_ready;
  logic [1:0]      gnt;
  logic [DBIT-1:0] rsp_data;
  logic            rsp_valid;
  logic            rsp_last;
  logic            done;
  logic            err;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            tx_full;
  logic            rd_uart;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            e_parity;
  logic            e_frame;

  modport master (
    input  req, cmd_data0, cmd_data1, cmd_valid, cmd_last,
    input  tx_full, r_data, rx_empty, e_parity, e_frame,
    output cmd_ready, gnt, rsp_data, rsp_valid, rsp_last, done, err,
    output wr_uart, w_data, rd_uart
  );

  modport slave (
    output req, cmd_data0, cmd_data1, cmd_valid, cmd_last,
    output tx_full, r_data, rx_empty, e_parity, e_frame,
    input  cmd_ready, gnt, rsp_data, rsp_valid, rsp_last, done, err,
    input  wr_uart, w_data, rd_uart
  );
endinterface

// File: rtl/uart_sched.sv
// Shares one uart between two requesters: sends a command, collects the reply up to
// the prompt byte, hands it back to the granted requester, then rearbitrates round-robin.
module uart_sched #(
  parameter int unsigned         DBIT     = 8,
  parameter logic [DBIT-1:0]     PROMPT   = DBIT'(8'h3E),
  parameter int unsigned         TMO_BITS = 24,
  parameter logic [TMO_BITS-1:0] TMO      = TMO_BITS'(5_000_000)
) (
  input  logic         clk,
  input  logic         reset,
  uart_sched_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, TX_WAIT, TX_PULSE, TX_GAP, RX_WAIT, RX_PULSE, RX_GAP, RX_EMIT, FINISH
  } state_e;

  state_e              state_q;
  logic                last_q;
  logic                sel_q;
  logic [1:0]          gnt_q;
  logic [1:0]          cmd_ready_q;
  logic [DBIT-1:0]     w_data_q;
  logic                wr_q;
  logic                rd_q;
  logic                last_flag_q;
  logic [1:0]          gap_q;
  logic [TMO_BITS-1:0] tmo_q;
  logic                err_flag_q;
  logic [DBIT-1:0]     rsp_data_q;
  logic                rsp_valid_q;
  logic                rsp_last_q;
  logic                done_q;
  logic                err_q;

  logic                pick_d;
  logic                cur_valid_c;
  logic                cur_last_c;
  logic [DBIT-1:0]     cur_data_c;
  logic                in_rx_c;

  // Prefer the requester that was not served last; fall back to the other one.
  assign pick_d      = bus.req[~last_q] ? ~last_q : last_q;
  assign cur_valid_c = sel_q ? bus.cmd_valid[1] : bus.cmd_valid[0];
  assign cur_last_c  = sel_q ? bus.cmd_last[1]  : bus.cmd_last[0];
  assign cur_data_c  = sel_q ? bus.cmd_data1    : bus.cmd_data0;
  assign in_rx_c     = (state_q == RX_WAIT) || (state_q == RX_PULSE) ||
                       (state_q == RX_GAP)  || (state_q == RX_EMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      gnt_q       <= '0;
      cmd_ready_q <= '0;
      w_data_q    <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      last_flag_q <= 1'b0;
      gap_q       <= '0;
      tmo_q       <= '0;
      err_flag_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      if (in_rx_c && (bus.e_parity || bus.e_frame)) err_flag_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            sel_q      <= pick_d;
            gnt_q      <= pick_d ? 2'b10 : 2'b01;
            err_flag_q <= 1'b0;
            state_q    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (cur_valid_c && !bus.tx_full) begin
            cmd_ready_q <= gnt_q;
            w_data_q    <= cur_data_c;
            last_flag_q <= cur_last_c;
            wr_q        <= 1'b1;
            state_q     <= TX_PULSE;
          end
        end
        TX_PULSE: begin
          gap_q   <= '0;
          state_q <= TX_GAP;
        end
        // Two low cycles let the uart's write edge detector re-arm.
        TX_GAP: begin
          if (gap_q == 2'd1) begin
            tmo_q   <= '0;
            state_q <= last_flag_q ? RX_WAIT : TX_WAIT;
          end else begin
            gap_q <= gap_q + 2'd1;
          end
        end
        RX_WAIT: begin
          if (!bus.rx_empty) begin
            rd_q    <= 1'b1;
            state_q <= RX_PULSE;
          end else if (tmo_q == TMO - TMO_BITS'(1)) begin
            err_flag_q <= 1'b1;
            state_q    <= FINISH;
          end else begin
            tmo_q <= tmo_q + TMO_BITS'(1);
          end
        end
        RX_PULSE: begin
          gap_q   <= '0;
          state_q <= RX_GAP;
        end
        // Three cycles cover edge detect, FIFO pop and the uart's r_data register.
        RX_GAP: begin
          if (gap_q == 2'd2) begin
            rsp_data_q  <= bus.r_data;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (bus.r_data == PROMPT);
            state_q     <= RX_EMIT;
          end else begin
            gap_q <= gap_q + 2'd1;
          end
        end
        RX_EMIT: begin
          if (rsp_last_q) begin
            state_q <= FINISH;
          end else begin
            tmo_q   <= '0;
            state_q <= RX_WAIT;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          err_q   <= err_flag_q;
          gnt_q   <= '0;
          last_q  <= sel_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.w_data    = w_data_q;
  assign bus.wr_uart   = wr_q;
  assign bus.rd_uart   = rd_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_sched.sv
// Scoreboard bench for uart_sched: requester command queues, a small uart model and
// expected TX bytes, replies, grants and done/err results checked as the DUT produces them.
module tb_uart_sched;
  localparam int unsigned DBIT   = 8;
  localparam int unsigned TMO_TB = 100;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_wr_cyc = 0;
  int   wr_cnt  = 0;
  int   rsp_cnt = 0;

  logic [8:0] cmdq0[$];
  logic [8:0] cmdq1[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [8:0] rspq[$];
  logic       doneq[$];
  logic [1:0] gntq[$];

  uart_sched_if #(.DBIT(DBIT)) bus();

  uart_sched #(
    .DBIT(DBIT), .PROMPT(8'h3E), .TMO_BITS(24), .TMO(24'd100)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Requester drivers: present the queue head, advance on cmd_ready.
  always @(negedge clk) begin
    if (bus.cmd_ready[0] && cmdq0.size() > 0) cmdq0.delete(0);
    if (bus.cmd_ready[1] && cmdq1.size() > 0) cmdq1.delete(0);
    bus.cmd_valid = {cmdq1.size() > 0, cmdq0.size() > 0};
    {bus.cmd_last[0], bus.cmd_data0} = (cmdq0.size() > 0) ? cmdq0[0] : 9'h0;
    {bus.cmd_last[1], bus.cmd_data1} = (cmdq1.size() > 0) ? cmdq1[0] : 9'h0;
  end

  // uart RX side: rd_uart pops the FIFO into r_data.
  always @(negedge clk) begin
    if (bus.rd_uart && rxq.size() > 0) bus.r_data = rxq.pop_front();
    bus.rx_empty = (rxq.size() == 0);
  end

  // Output monitor and scoreboard.
  int         wr_low  = 0;
  bit         wr_seen = 1'b0;
  logic       rd_prev = 1'b0;
  logic [1:0] gnt_prev = 2'b00;
  always @(negedge clk) begin
    if (bus.wr_uart === 1'b1) begin
      if (wr_seen) chk("wr_gap", 32'(wr_low >= 3), 32'd1);
      if (txq.size() == 0) chk("wr_unexp", 32'(bus.w_data), 32'hFFFF);
      else chk("w_data", 32'(bus.w_data), 32'(txq.pop_front()));
      wr_seen = 1'b1;
      wr_low = 0;
      wr_cnt++;
      last_wr_cyc = cyc;
    end else begin
      wr_low++;
    end
    if (bus.rd_uart === 1'b1) chk("rd_edge", 32'(rd_prev), 32'd0);
    rd_prev = bus.rd_uart;
    if (|bus.cmd_ready) chk("rdy_gnt", 32'(bus.cmd_ready & ~bus.gnt), 32'd0);
    if (bus.gnt != gnt_prev && bus.gnt != 2'b00) begin
      chk("gnt_gap", 32'(gnt_prev), 32'd0);
      if (gntq.size() == 0) chk("gnt_unexp", 32'(bus.gnt), 32'd0);
      else chk("gnt", 32'(bus.gnt), 32'(gntq.pop_front()));
    end
    gnt_prev = bus.gnt;
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (rspq.size() == 0) chk("rsp_unexp", 32'(bus.rsp_data), 32'hFFFF);
      else chk("rsp", 32'({bus.rsp_last, bus.rsp_data}), 32'(rspq.pop_front()));
    end
    if (bus.done === 1'b1) begin
      chk("gnt_at_done", 32'(bus.gnt), 32'd0);
      if (doneq.size() == 0) chk("done_unexp", 32'(bus.done), 32'd0);
      else chk("err", 32'(bus.err), 32'(doneq.pop_front()));
    end
  end

  task automatic queue_txn(input int r, input string cmd, input string rsp, input logic exp_err);
    for (int i = 0; i < cmd.len(); i++) begin
      if (r == 0) cmdq0.push_back({i == cmd.len() - 1, cmd[i]});
      else        cmdq1.push_back({i == cmd.len() - 1, cmd[i]});
      txq.push_back(cmd[i]);
    end
    for (int i = 0; i < rsp.len(); i++) begin
      rxq.push_back(rsp[i]);
      rspq.push_back({rsp[i] == 8'h3E, rsp[i]});
    end
    gntq.push_back((r == 0) ? 2'b01 : 2'b10);
    doneq.push_back(exp_err);
  endtask

  // ev: 0 done, 1 rsp_valid, 2 rd_uart, 3 wr_uart; n returns negedges waited.
  task automatic wait_ev(input int ev, input int budget, input string tag, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (ev)
        0:       hit = bus.done;
        1:       hit = bus.rsp_valid;
        2:       hit = bus.rd_uart;
        default: hit = bus.wr_uart;
      endcase
    end while (hit !== 1'b1 && n < budget);
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt), 32'd0);
    chk({tag, "_wr"},   32'(bus.wr_uart), 32'd0);
    chk({tag, "_rd"},   32'(bus.rd_uart), 32'd0);
    chk({tag, "_rdy"},  32'(bus.cmd_ready), 32'd0);
    chk({tag, "_rspv"}, 32'({bus.rsp_valid, bus.rsp_last}), 32'd0);
    chk({tag, "_done"}, 32'({bus.done, bus.err}), 32'd0);
    chk({tag, "_data"}, 32'({bus.w_data, bus.rsp_data}), 32'd0);
  endtask

  initial begin
    int n;
    int base_wr;
    int base_rsp;
    int hits;
    reset = 1'b1;
    bus.req = 2'b00;
    bus.tx_full = 1'b0;
    bus.e_parity = 1'b0;
    bus.e_frame = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Round robin with both requesting from reset: 01, 10, 01.
    queue_txn(0, "AT\r", "A>", 1'b0);
    queue_txn(1, "01\r", "B>", 1'b0);
    queue_txn(0, "02\r", "C>", 1'b0);
    bus.req = 2'b11;
    for (int k = 0; k < 3; k++) wait_ev(0, 400, "rr_done", n);
    bus.req = 2'b00;

    // Single command with a 9-byte reply.
    base_wr = wr_cnt;
    base_rsp = rsp_cnt;
    queue_txn(0, "01\r", "41 0B 64>", 1'b0);
    bus.req = 2'b01;
    wait_ev(0, 600, "single_done", n);
    bus.req = 2'b00;
    chk("single_wr_cnt", 32'(wr_cnt - base_wr), 32'd3);
    chk("single_rsp_cnt", 32'(rsp_cnt - base_rsp), 32'd9);

    // Framing error in the middle of the reply.
    queue_txn(1, "AT\r", "OK>", 1'b1);
    bus.req = 2'b10;
    wait_ev(1, 400, "fe_first_rsp", n);
    bus.e_frame = 1'b1;
    @(negedge clk);
    bus.e_frame = 1'b0;
    wait_ev(0, 400, "fe_done", n);
    bus.req = 2'b00;

    // TX backpressure window.
    bus.tx_full = 1'b1;
    queue_txn(0, "ATZ\r", "OK>", 1'b0);
    bus.req = 2'b01;
    hits = 0;
    repeat (50) begin
      @(negedge clk);
      hits += int'(bus.wr_uart) + int'(|bus.cmd_ready);
    end
    chk("bp_quiet", 32'(hits), 32'd0);
    bus.tx_full = 1'b0;
    wait_ev(3, 10, "bp_wr", n);
    chk("bp_lat", 32'(n <= 2), 32'd1);
    wait_ev(0, 600, "bp_done", n);
    bus.req = 2'b00;

    // Timeout with no reply at all.
    queue_txn(0, "X\r", "", 1'b1);
    bus.req = 2'b01;
    wait_ev(0, 400, "tmo_done", n);
    bus.req = 2'b00;
    chk("tmo_lat", 32'(cyc - last_wr_cyc), 32'(TMO_TB + 4));
    @(negedge clk);
    chk("tmo_gnt", 32'(bus.gnt), 32'd0);

    // Reset during RX_GAP on a requester-1 transaction; requester 0 must win next.
    queue_txn(1, "Y\r", "Z>", 1'b0);
    bus.req = 2'b10;
    wait_ev(2, 400, "rst_rd", n);
    @(negedge clk);
    reset = 1'b1;
    rxq.delete();
    @(negedge clk);
    chk_outputs_zero("midrst");
    reset = 1'b0;
    rspq.delete();
    doneq.delete();
    queue_txn(0, "A\r", "1>", 1'b0);
    queue_txn(1, "B\r", "2>", 1'b0);
    bus.req = 2'b11;
    wait_ev(0, 400, "post_rst_done0", n);
    wait_ev(0, 400, "post_rst_done1", n);
    bus.req = 2'b00;

    repeat (5) @(negedge clk);
    chk("left_tx", 32'(txq.size()), 32'd0);
    chk("left_rsp", 32'(rspq.size()), 32'd0);
    chk("left_done", 32'(doneq.size()), 32'd0);
    chk("left_gnt", 32'(gntq.size()), 32'd0);
    chk("left_cmd", 32'(cmdq0.size() + cmdq1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_sched.md
# uart_sched

Transaction scheduler that shares one `uart` instance between two requesters. It serializes each command onto the UART TX FIFO and collects the reply from the RX FIFO until the prompt byte arrives. It returns that reply to the granted requester, then rearbitrates round-robin. It sits between the uart and the query engines, for example the boost and AFR pollers, and is the only block that drives `wr_uart` and `rd_uart`.

## Interface
- `DBIT`, 8: data width; matches the uart.
- `PROMPT`, 8'h3E: byte that ends a response (`>`).
- `TMO_BITS`, 24: width of the response timeout counter.
- `TMO`, 24'd5_000_000: idle cycles allowed between RX bytes before abort.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 2: request lines, one per requester; held high until `done`.
- `cmd_data0`, `cmd_data1` in DBIT: command byte from each requester.
- `cmd_valid` in 2: command byte valid, per requester.
- `cmd_last` in 2: marks the final command byte, per requester.
- `cmd_ready` out 2: one-cycle accept strobe; only the granted bit can pulse.
- `gnt` out 2: one-hot grant; held for the whole transaction.
- `rsp_data` out DBIT: response byte.
- `rsp_valid` out 1: one-cycle strobe per response byte, including PROMPT.
- `rsp_last` out 1: asserted with the PROMPT byte.
- `done` out 1: one-cycle end-of-transaction strobe.
- `err` out 1: valid with `done`; 1 means the transaction ended on timeout, parity error or framing error.
- `wr_uart` out 1: write request to the uart (edge-triggered there).
- `w_data` out DBIT: TX byte.
- `tx_full` in 1: uart TX FIFO full.
- `rd_uart` out 1: read request to the uart (edge-triggered there).
- `r_data` in DBIT: registered RX byte from the uart.
- `rx_empty` in 1: uart RX FIFO empty.
- `e_parity`, `e_frame` in 1: uart receive error flags.

## Operation
- States: IDLE, TX_WAIT, TX_PULSE, TX_GAP, RX_WAIT, RX_PULSE, RX_GAP, RX_EMIT, FINISH.
- **IDLE**
  - Arbitrate round-robin among the `req` bits. The pointer `last` resets to 1, so requester 0 wins the first tie.
  - Grant the requester that is not `last` if it is requesting; otherwise grant the other one. Then go to TX_WAIT.
- **TX_WAIT**
  - Wait for the granted `cmd_valid` with `tx_full`=0.
  - Pulse `cmd_ready`, latch the byte into `w_data` and the `cmd_last` value, then go to TX_PULSE.
- **TX_PULSE**
  - `wr_uart`=1 for exactly one cycle, then go to TX_GAP.
- **TX_GAP**
  - Hold `wr_uart`=0 for 2 cycles so the uart's edge detector re-arms and `tx_full` settles.
  - Then go to RX_WAIT if the latched last flag is set, otherwise back to TX_WAIT.
- **RX_WAIT**
  - Clear the timeout counter on entry.
  - If `rx_empty`=0, go to RX_PULSE.
  - Otherwise increment the counter; when it reaches `TMO`-1, set `err` and go to FINISH.
- **RX_PULSE**
  - `rd_uart`=1 for one cycle, then go to RX_GAP.
- **RX_GAP**
  - 3 cycles with `rd_uart`=0: edge detect, FIFO pop, `r_data` register.
  - Then capture `r_data` and go to RX_EMIT.
- **RX_EMIT**
  - Drive `rsp_data`, pulse `rsp_valid`, and set `rsp_last` if the byte equals PROMPT.
  - Go to FINISH on PROMPT, otherwise back to RX_WAIT.
- **FINISH**
  - Pulse `done` with `err`, drop `gnt`, set `last` to the served requester, go to IDLE.
- **Error flags:** `e_parity` or `e_frame` sampled high in any RX state sets a sticky internal error. It is reported on `err` at `done` and cleared on the next grant.
- **Requester dropping out:** if the granted `req` drops before `done`, the transaction still completes. No aborts mid-transaction.
- **Command bytes:** `cmd_valid` of the non-granted requester is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last`=1, timeout counter 0, error flag 0.
- **Reset mid-transaction:** reset in any state returns to IDLE on the next edge. `wr_uart` and `rd_uart` drop to 0 the same cycle. The uart FIFOs are reset by the same `reset`.
- **Grant latency:** `gnt` is asserted 1 cycle after `req` is sampled in IDLE.
- **TX rate:** minimum 4 cycles per command byte (TX_WAIT, TX_PULSE, 2× TX_GAP).
- **RX rate:** minimum 6 cycles per response byte (RX_WAIT, RX_PULSE, 3× RX_GAP, RX_EMIT).
- **Edge-trigger rule:** `wr_uart` and `rd_uart` are never high in consecutive cycles.
- **Timeout:** with `rx_empty` held at 1 from RX_WAIT entry, `done`/`err`=1 arrive `TMO`+1 cycles later.
- **Back-to-back transactions:** after `done`, IDLE takes 1 cycle before a new `gnt`. `gnt` is all-zero for at least 1 cycle between transactions.

## Test plan
- **Single command:** req=01, bytes "01"+0x0D (`cmd_last` on 0x0D).
  - Expect 3 `wr_uart` pulses carrying 0x30, 0x31, 0x0D, each separated by ≥3 low cycles.
  - Loop back "41 0B 64>" on rx; `rsp_valid` pulses 9 times, `rsp_last` on 0x3E, `done`=1, `err`=0.
- **Round robin:** req=11 held through 3 transactions.
  - Expect `gnt` sequence 01, 10, 01; `done` count = 3.
- **TX backpressure:** hold `tx_full`=1 for 50 cycles while `cmd_valid`=1.
  - Expect no `wr_uart` and no `cmd_ready` in that window; first `wr_uart` ≤2 cycles after `tx_full` falls.
- **Timeout:** TMO=100 with no reply.
  - Expect `done`=1 and `err`=1 exactly 101 cycles after RX_WAIT entry, then `gnt`=00.
- **Framing error:** pulse `e_frame` during the reply "OK>".
  - Expect all 3 bytes delivered; `err`=1 with `done`.
- **Reset mid-RX:** assert `reset` in RX_GAP.
  - Next cycle all outputs are 0 and state is IDLE; with req=11, the next grant goes to requester 0.
